nonce_rr_scheduler: RTL and testbench
=====================================

# nonce_rr_scheduler

Round-robin scheduler that shares the hub's single `serial_transmit` uplink among `SLAVES` nonce sources (local miners' `slave_receive` outputs plus external ports). It buffers each slave's found nonces in a small per-slave FIFO. Grants are issued fairly. It sequences the transmitter through its send/busy handshake so that no nonce is lost while the uplink is occupied. Drops occur only on per-slave FIFO overflow, and each drop is counted.

## Interface
Parameters:
- `SLAVES`, 3, number of nonce sources (≥1)
- `DEPTH_LOG2`, 1, per-slave FIFO depth = 2^DEPTH_LOG2 entries
- `BUSY_TIMEOUT`, 4, cycles to wait for `serial_busy` to rise after a send

Ports. Clock and reset: one clock; reset is synchronous and active-high.
- `hash_clk`  in  1  sole clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `slave_nonces`  in  SLAVES*32  slave i nonce at bits [i*32+31:i*32]
- `new_nonces`  in  SLAVES  bit i high for one cycle = slave i nonce valid that cycle
- `serial_busy`  in  1  transmitter busy
- `serial_send`  out  1  one-cycle send strobe to transmitter
- `golden_nonce`  out  32  nonce being transmitted, held until next grant
- `pending`  out  SLAVES  bit i = slave i FIFO non-empty
- `drop_count`  out  16  saturating count of nonces dropped on FIFO full

## Operation
- Per-slave FIFO: write pointer, read pointer and count (DEPTH_LOG2+1 bits).
  - Push when `new_nonces[i]`=1.
  - Pop only on grant to slave i.
- Full FIFO with no pop that cycle: the push is dropped, and `drop_count` increments, saturating at 0xFFFF.
- Simultaneous drops from k slaves in one cycle: `drop_count` += k, saturating.
- Simultaneous push and pop on the same FIFO (including a full one): both are performed, count unchanged, no drop.
- `last_grant` register (index) drives round-robin. Search order is `last_grant`+1, +2, … modulo SLAVES. The first slave with `pending` set wins.
- FSM states:
  - IDLE: if `serial_busy`=0 and any `pending` bit set → pop the winner's head into `golden_nonce`, set `last_grant`=winner, go to SEND. Otherwise stay.
  - SEND: `serial_send`=1 this cycle only → WAIT_BUSY, clear timeout counter.
  - WAIT_BUSY: `serial_busy`=1 → WAIT_DONE. If instead the counter reaches BUSY_TIMEOUT → IDLE (nonce counted as sent, no retry).
  - WAIT_DONE: `serial_busy`=0 → IDLE.
- `golden_nonce` changes only on a grant. It stays stable from SEND until the next grant.
- Nonce values are opaque 32-bit data; no comparison, no dedup.

## Timing
- Reset values:
  - state IDLE
  - `serial_send`=0, `golden_nonce`=0, `drop_count`=0
  - all FIFOs empty, `pending`=0
  - `last_grant`=SLAVES-1, so slave 0 has first priority
- Reset mid-operation: FSM returns to IDLE and buffered nonces are discarded. IDLE will not grant while `serial_busy`=1, so an in-flight transmitter word completes unharmed.
- Latency with an idle uplink:
  - pulse on `new_nonces[i]` in cycle N
  - `pending[i]`=1 in N+1; grant registered at end of N+1
  - `serial_send`=1 and `golden_nonce` valid in N+2
- Minimum spacing between consecutive `serial_send` pulses: 4 cycles (SEND, WAIT_BUSY, WAIT_DONE, IDLE), plus the transmitter's busy time.
- `serial_send` is never high for two consecutive cycles.
- `pending` reflects FIFO state after the current edge's push/pop (registered).

## Test plan
- Reset, then pulse `new_nonces`=3'b001 with slave0 = 0xDEADBEEF, and model busy as high 3 cycles after send → `serial_send` pulse 2 cycles after the input pulse, `golden_nonce`=0xDEADBEEF, `drop_count`=0.
- Same-cycle pulse on all 3 slaves (0x11111111, 0x22222222, 0x33333333) → sends in order slave0, slave1, slave2, each after the previous busy falls.
- Hold `serial_busy`=1, then push 3 nonces into slave1 (depth 2) → `drop_count`=1, and only the first two are sent, in FIFO order, once busy drops.
- Fairness: slave0 re-pulsed after every grant while slaves 1 and 2 each hold one nonce → grant sequence 0,1,2,0; slave0 never granted twice consecutively while others are pending.
- `serial_busy` never rises after a send → FSM returns to IDLE after BUSY_TIMEOUT=4 cycles, and the next pending nonce is sent.
- Assert `reset` in WAIT_DONE with 2 nonces buffered → next cycle all outputs at reset values, `pending`=0, and no `serial_send` until new input arrives.

Source files
------------

// File: rtl/nonce_rr_scheduler.sv
// Shares one serial uplink among SLAVES nonce sources: per-slave FIFOs, round-robin grant, send/busy sequencing.
// Nonce pulse to serial_send is 2 cycles on an idle uplink; pushes into a full FIFO are dropped and counted.
module nonce_rr_scheduler #(
  parameter int SLAVES       = 3,
  parameter int DEPTH_LOG2   = 1,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                   hash_clk,
  input  logic                   reset,
  input  logic [SLAVES*32-1:0]   slave_nonces,
  input  logic [SLAVES-1:0]      new_nonces,
  input  logic                   serial_busy,
  output logic                   serial_send,
  output logic [31:0]            golden_nonce,
  output logic [SLAVES-1:0]      pending,
  output logic [15:0]            drop_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int IW    = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int TW    = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [IW-1:0]     last_grant_q;
  logic [IW-1:0]     winner;
  logic [IW-1:0]     cand;
  int                idx;
  logic              any_pend;
  logic              grant;
  logic [31:0]       golden_q;
  logic [15:0]       drop_q, drop_d;
  logic [16:0]       drop_sum;
  logic [SLAVES-1:0] pop;
  logic [SLAVES-1:0] drop;
  logic [31:0]       head [SLAVES];

  for (genvar g = 0; g < SLAVES; g++) begin : g_fifo
    logic [31:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_q, rd_q;
    logic [CW-1:0]         cnt_q;
    logic                  full;
    logic                  wr_en;

    // A full FIFO still accepts a push when it is popped in the same cycle.
    assign full       = (cnt_q == CW'(DEPTH));
    assign pop[g]     = grant && (winner == IW'(g));
    assign drop[g]    = new_nonces[g] && full && !pop[g];
    assign wr_en      = new_nonces[g] && !drop[g];
    assign pending[g] = (cnt_q != '0);
    assign head[g]    = mem_q[rd_q];

    always_ff @(posedge hash_clk) begin
      if (reset) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (wr_en) begin
          mem_q[wr_q] <= slave_nonces[g*32 +: 32];
          wr_q        <= wr_q + 1'b1;
        end
        if (pop[g]) rd_q <= rd_q + 1'b1;
        if (wr_en && !pop[g])      cnt_q <= cnt_q + 1'b1;
        else if (pop[g] && !wr_en) cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Scan from farthest to nearest so the nearest pending slave after last_grant wins.
  always_comb begin
    winner   = last_grant_q;
    any_pend = 1'b0;
    idx      = 0;
    cand     = '0;
    for (int off = SLAVES; off >= 1; off--) begin
      idx  = (int'(last_grant_q) + off) % SLAVES;
      cand = IW'(idx);
      if (pending[cand]) begin
        winner   = cand;
        any_pend = 1'b1;
      end
    end
  end

  assign grant = (state_q == IDLE) && !serial_busy && any_pend;

  always_comb begin
    drop_sum = {1'b0, drop_q};
    for (int i = 0; i < SLAVES; i++) drop_sum = drop_sum + 17'(drop[i]);
    drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE:      if (grant) state_d = SEND;
      SEND: begin
        state_d = WAIT_BUSY;
        tmo_d   = '0;
      end
      // A transmitter that never acknowledges is treated as having sent the word.
      WAIT_BUSY: begin
        if (serial_busy)                          state_d = WAIT_DONE;
        else if (tmo_q == TW'(BUSY_TIMEOUT - 1))  state_d = IDLE;
        else                                      tmo_d   = tmo_q + 1'b1;
      end
      WAIT_DONE: if (!serial_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      tmo_q        <= '0;
      golden_q     <= '0;
      drop_q       <= '0;
      last_grant_q <= IW'(SLAVES - 1);
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      drop_q  <= drop_d;
      if (grant) begin
        golden_q     <= head[winner];
        last_grant_q <= winner;
      end
    end
  end

  assign serial_send  = (state_q == SEND);
  assign golden_nonce = golden_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_nonce_rr_scheduler.sv
// Bench for nonce_rr_scheduler: transmitter busy model, send scoreboard, vector table and corner-case sequences.
module tb_nonce_rr_scheduler;
  localparam int SLAVES       = 3;
  localparam int DEPTH_LOG2   = 1;
  localparam int BUSY_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [95:0] slave_nonces;
  logic [2:0]  new_nonces;
  logic        serial_busy;
  logic        serial_send;
  logic [31:0] golden_nonce;
  logic [2:0]  pending;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  nonce_rr_scheduler #(.SLAVES(SLAVES), .DEPTH_LOG2(DEPTH_LOG2), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .hash_clk(clk), .reset(reset), .slave_nonces(slave_nonces), .new_nonces(new_nonces),
    .serial_busy(serial_busy), .serial_send(serial_send), .golden_nonce(golden_nonce),
    .pending(pending), .drop_count(drop_count)
  );

  typedef struct {
    int          slv;
    logic [31:0] val;
    logic [2:0]  exp_pend;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          nsent = 0;
  int          last_send_cyc = 0;
  int          busy_cnt = 0;
  int          bmode = 0;   // 0: busy for 3 cycles after each send, 1: held high, 2: never busy
  logic        prev_send = 1'b0;
  logic [31:0] exp_q[$];
  vec_t        tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] mk(input int slv, input logic [31:0] val);
    logic [95:0] v;
    v = '0;
    v[slv*32 +: 32] = val;
    return v;
  endfunction

  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (serial_send === 1'b1) begin
      chk("send_not_back_to_back", {31'd0, prev_send}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_send: golden %h with empty scoreboard", golden_nonce);
      end else begin
        e = exp_q.pop_front();
        chk("golden_nonce", golden_nonce, e);
      end
      nsent++;
      last_send_cyc = cyc;
      if (bmode == 0) busy_cnt = 3;
    end
    prev_send = serial_send;
    if (bmode == 1) serial_busy = 1'b1;
    else if (bmode == 0 && busy_cnt > 0) begin
      serial_busy = 1'b1;
      busy_cnt--;
    end else serial_busy = 1'b0;
  endtask

  task automatic pulse(input logic [2:0] m, input logic [95:0] v);
    slave_nonces = v;
    new_nonces   = m;
    tick();
    new_nonces   = '0;
  endtask

  task automatic wait_send(output int at);
    int n0;
    bit got;
    n0  = nsent;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (nsent > n0) got = 1'b1;
    end
    chk("send_within_budget", {31'd0, got}, 32'd1);
    at = last_send_cyc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0, s1, s2, n0;
    reset        = 1'b1;
    slave_nonces = '0;
    new_nonces   = '0;
    serial_busy  = 1'b0;

    tbl[0] = '{0, 32'hDEADBEEF, 3'b001};
    tbl[1] = '{1, 32'hCAFEF00D, 3'b010};
    tbl[2] = '{2, 32'h12345678, 3'b100};
    tbl[3] = '{0, 32'h00000000, 3'b001};
    tbl[4] = '{2, 32'hFFFFFFFF, 3'b100};

    tick();
    tick();
    chk("reset_send", {31'd0, serial_send}, 32'd0);
    chk("reset_golden", golden_nonce, 32'd0);
    chk("reset_drop", {16'd0, drop_count}, 32'd0);
    chk("reset_pending", {29'd0, pending}, 32'd0);
    reset = 1'b0;
    repeat (2) tick();

    // Single nonces on an idle uplink: pending after 1 cycle, send after 2.
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(tbl[i].val);
      pulse(3'(1 << tbl[i].slv), mk(tbl[i].slv, tbl[i].val));
      chk("vec_pending", {29'd0, pending}, {29'd0, tbl[i].exp_pend});
      tick();
      chk("vec_send_latency", {31'd0, serial_send}, 32'd1);
      chk("vec_drop", {16'd0, drop_count}, 32'd0);
      repeat (8) tick();
    end

    // All three slaves in one cycle: served 0,1,2, one busy window apart.
    exp_q.push_back(32'h11111111);
    exp_q.push_back(32'h22222222);
    exp_q.push_back(32'h33333333);
    pulse(3'b111, {32'h33333333, 32'h22222222, 32'h11111111});
    chk("all3_pending", {29'd0, pending}, 32'd7);
    wait_send(s0);
    wait_send(s1);
    wait_send(s2);
    chk("all3_gap01", s1 - s0, 32'd5);
    chk("all3_gap12", s2 - s1, 32'd5);
    repeat (4) tick();
    chk("all3_pending_after", {29'd0, pending}, 32'd0);

    // Overflow of slave1 while the uplink is held busy.
    bmode = 1;
    tick();
    pulse(3'b010, mk(1, 32'hA1A1A1A1));
    pulse(3'b010, mk(1, 32'hA2A2A2A2));
    pulse(3'b010, mk(1, 32'hA3A3A3A3));
    chk("ovf_drop", {16'd0, drop_count}, 32'd1);
    chk("ovf_pending", {29'd0, pending}, 32'd2);
    exp_q.push_back(32'hA1A1A1A1);
    exp_q.push_back(32'hA2A2A2A2);
    bmode = 0;
    busy_cnt = 0;
    serial_busy = 1'b0;
    wait_send(s0);
    wait_send(s1);
    n0 = nsent;
    repeat (10) tick();
    chk("ovf_no_extra_send", nsent, n0);
    chk("ovf_pending_after", {29'd0, pending}, 32'd0);

    // Multi-slave drops and saturation of the drop counter.
    bmode = 1;
    do_reset();
    tick();
    pulse(3'b111, '0);
    pulse(3'b111, '0);
    chk("sat_no_drop_yet", {16'd0, drop_count}, 32'd0);
    pulse(3'b111, '0);
    chk("multi_drop", {16'd0, drop_count}, 32'd3);
    for (int i = 0; i < 21844; i++) pulse(3'b111, '0);
    chk("drop_at_max", {16'd0, drop_count}, 32'h0000FFFF);
    pulse(3'b111, '0);
    chk("drop_saturate", {16'd0, drop_count}, 32'h0000FFFF);

    // Fairness: slave0 re-pulsed after its grant still yields 0,1,2,0.
    do_reset();
    chk("fair_reset_drop", {16'd0, drop_count}, 32'd0);
    tick();
    pulse(3'b111, {32'hB0B0B0B0, 32'hA0A0A0A0, 32'hC0C0C0C0});
    exp_q.push_back(32'hC0C0C0C0);
    exp_q.push_back(32'hA0A0A0A0);
    exp_q.push_back(32'hB0B0B0B0);
    exp_q.push_back(32'hC1C1C1C1);
    bmode = 0;
    busy_cnt = 0;
    serial_busy = 1'b0;
    wait_send(s0);
    pulse(3'b001, mk(0, 32'hC1C1C1C1));
    wait_send(s0);
    wait_send(s1);
    wait_send(s2);
    repeat (6) tick();
    chk("fair_pending_after", {29'd0, pending}, 32'd0);

    // Busy never rises: each send times out after BUSY_TIMEOUT cycles in WAIT_BUSY.
    bmode = 2;
    exp_q.push_back(32'h0000BBBB);
    exp_q.push_back(32'h0000AAAA);
    pulse(3'b011, {32'h0, 32'h0000BBBB, 32'h0000AAAA});
    wait_send(s0);
    wait_send(s1);
    chk("timeout_gap", s1 - s0, BUSY_TIMEOUT + 2);
    repeat (10) tick();

    // Reset while in WAIT_DONE with two nonces still buffered.
    bmode = 0;
    do_reset();
    exp_q.push_back(32'h50000001);
    pulse(3'b111, {32'h50000003, 32'h50000002, 32'h50000001});
    wait_send(s0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_send", {31'd0, serial_send}, 32'd0);
    chk("midrst_golden", golden_nonce, 32'd0);
    chk("midrst_drop", {16'd0, drop_count}, 32'd0);
    chk("midrst_pending", {29'd0, pending}, 32'd0);
    reset = 1'b0;
    n0 = nsent;
    repeat (15) tick();
    chk("midrst_no_send", nsent, n0);
    exp_q.push_back(32'h7777AAAA);
    pulse(3'b100, mk(2, 32'h7777AAAA));
    wait_send(s0);
    repeat (6) tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
